// File: rtl/cacheline_burst_adaptor_pkg.sv
// Shared types and default geometry for the cache-line to memory-burst adaptor.
package cacheline_burst_adaptor_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 32;
  localparam int unsigned LINE_WIDTH_DEF = 256;
  localparam int unsigned BEAT_WIDTH_DEF = 64;

  typedef enum logic [1:0] {
    IDLE,
    READ_BURST,
    WRITE_BURST,
    DONE
  } state_t;

endpackage

// File: rtl/cacheline_burst_adaptor_if.sv
// Cache-side line port and memory-side burst port bundled together.
interface cacheline_burst_adaptor_if
  import cacheline_burst_adaptor_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned LINE_WIDTH = LINE_WIDTH_DEF,
  parameter int unsigned BEAT_WIDTH = BEAT_WIDTH_DEF
);
  logic [ADDR_WIDTH-1:0] line_address;
  logic                  line_read;
  logic                  line_write;
  logic [LINE_WIDTH-1:0] line_wdata;
  logic [LINE_WIDTH-1:0] line_rdata;
  logic                  line_resp;
  logic [ADDR_WIDTH-1:0] burst_address;
  logic                  burst_read;
  logic                  burst_write;
  logic [BEAT_WIDTH-1:0] burst_wdata;
  logic [BEAT_WIDTH-1:0] burst_rdata;
  logic                  burst_resp;

  modport slave (
    input  line_address, line_read, line_write, line_wdata, burst_rdata, burst_resp,
    output line_rdata, line_resp, burst_address, burst_read, burst_write, burst_wdata
  );

  modport master (
    output line_address, line_read, line_write, line_wdata, burst_rdata, burst_resp,
    input  line_rdata, line_resp, burst_address, burst_read, burst_write, burst_wdata
  );
endinterface

// File: rtl/cacheline_burst_adaptor_control.sv
// Request FSM and beat counter for the burst adaptor.
module cacheline_burst_adaptor_control
  import cacheline_burst_adaptor_pkg::*;
#(
  parameter int unsigned BEATS = 4,
  localparam int unsigned CW = $clog2(BEATS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          line_read,
  input  logic          line_write,
  input  logic          burst_resp,
  output state_t        state,
  output logic [CW-1:0] beat,
  output logic          accept,
  output logic          take,
  output logic          last,
  output logic          op_write
);
  state_t state_next;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    take       = 1'b0;
    last       = (beat == CW'(BEATS - 1));
    case (state)
      IDLE: begin
        // Write wins when both are raised; the read is left for the cache to reissue.
        if (line_write) begin
          state_next = WRITE_BURST;
          accept     = 1'b1;
        end else if (line_read) begin
          state_next = READ_BURST;
          accept     = 1'b1;
        end
      end
      READ_BURST, WRITE_BURST: begin
        take = burst_resp;
        if (burst_resp && last) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      beat     <= '0;
      op_write <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        beat     <= '0;
        op_write <= line_write;
      end else if (take) begin
        beat <= last ? '0 : beat + 1'b1;
      end
    end
  end
endmodule

// File: rtl/cacheline_burst_adaptor.sv
// Splits 256-bit cache-line transfers into 64-bit memory bursts and reassembles reads.
// Optional BURST_ADAPTOR_PERF_EN adds clearable read/write completion counters.
module cacheline_burst_adaptor
  import cacheline_burst_adaptor_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned LINE_WIDTH = LINE_WIDTH_DEF,
  parameter int unsigned BEAT_WIDTH = BEAT_WIDTH_DEF
) (
  input logic clk,
  input logic rst_n,
  cacheline_burst_adaptor_if.slave bus
`ifdef BURST_ADAPTOR_PERF_EN
  ,
  input  logic        read_clear,
  input  logic        write_clear,
  output logic [31:0] read_count,
  output logic [31:0] write_count
`endif
);
  localparam int unsigned BEATS  = LINE_WIDTH / BEAT_WIDTH;
  localparam int unsigned CW     = $clog2(BEATS);
  localparam int unsigned OFFSET = $clog2(LINE_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << OFFSET;

  state_t                state;
  logic [CW-1:0]         beat;
  logic                  accept;
  logic                  take;
  logic                  last;
  logic                  op_write;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wbuf;
  logic [LINE_WIDTH-1:0] rbuf;
  logic [LINE_WIDTH-1:0] rbuf_next;
  logic [LINE_WIDTH-1:0] rdata_q;

  cacheline_burst_adaptor_control #(.BEATS(BEATS)) u_control (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_read  (bus.line_read),
    .line_write (bus.line_write),
    .burst_resp (bus.burst_resp),
    .state      (state),
    .beat       (beat),
    .accept     (accept),
    .take       (take),
    .last       (last),
    .op_write   (op_write)
  );

  always_comb begin
    rbuf_next = rbuf;
    rbuf_next[int'(beat)*BEAT_WIDTH +: BEAT_WIDTH] = bus.burst_rdata;
  end

  // Reads assemble in rbuf; the visible line only changes as the last beat lands,
  // so line_rdata stays stable from one read completion to the next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wbuf    <= '0;
      rbuf    <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q <= bus.line_address & ALIGN_MASK;
        wbuf   <= bus.line_wdata;
      end
      if (take && !op_write) begin
        rbuf <= rbuf_next;
        if (last) rdata_q <= rbuf_next;
      end
    end
  end

  assign bus.line_rdata    = rdata_q;
  assign bus.line_resp     = (state == DONE);
  assign bus.burst_address = addr_q;
  assign bus.burst_read    = (state == READ_BURST);
  assign bus.burst_write   = (state == WRITE_BURST);
  assign bus.burst_wdata   = wbuf[int'(beat)*BEAT_WIDTH +: BEAT_WIDTH];

`ifdef BURST_ADAPTOR_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_count  <= '0;
      write_count <= '0;
    end else begin
      if (read_clear) read_count <= '0;
      else if (state == DONE && !op_write) read_count <= read_count + 32'd1;
      if (write_clear) write_count <= '0;
      else if (state == DONE && op_write) write_count <= write_count + 32'd1;
    end
  end
`endif
endmodule
